// File: rtl/mul_behav_seq.sv
// Multi-cycle 32x32->64 multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Operands are captured on the start edge; done pulses for one cycle after LATENCY edges.
module mul_behav_seq #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk_core,
  input  logic        reset_n,
  input  logic        go,
  input  logic        sign0,
  input  logic        sign1,
  input  logic [31:0] m,
  input  logic [31:0] r,
  output logic        done,
  output logic [63:0] result
);

  // state | meaning
  // IDLE  | waiting for a start edge (go high)
  // BUSY  | counting down while go stays high; go low aborts
  // DONE  | result valid, done high for this single cycle
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        cap_en;
  logic        res_en;
  logic [31:0] m_q, r_q;
  logic        sign0_q, sign1_q;

  logic [31:0] op_m, op_r;
  logic        op_s0, op_s1;
  logic [63:0] m_ext, r_ext;
  logic [63:0] prod;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go) begin
          cap_en = 1'b1;
          if (LATENCY <= 1) begin
            state_nxt = ST_DONE;
            cnt_nxt   = 4'd0;
          end else begin
            state_nxt = ST_BUSY;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      ST_BUSY: begin
        if (!go) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt == 4'd1) begin
          state_nxt = ST_DONE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 4'd0;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign res_en = (state_nxt == ST_DONE);

  // With LATENCY=1 the start edge also writes the result, so bypass the capture registers.
  assign op_m  = cap_en ? m     : m_q;
  assign op_r  = cap_en ? r     : r_q;
  assign op_s0 = cap_en ? sign0 : sign0_q;
  assign op_s1 = cap_en ? sign1 : sign1_q;

  // Low 64 bits of the 64x64 product equal the low 64 bits of the 33x33 signed product.
  assign m_ext = {{32{op_s1 & op_m[31]}}, op_m};
  assign r_ext = {{32{op_s0 & op_r[31]}}, op_r};
  assign prod  = m_ext * r_ext;

  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      done    <= 1'b0;
      result  <= 64'd0;
      m_q     <= 32'd0;
      r_q     <= 32'd0;
      sign0_q <= 1'b0;
      sign1_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= res_en;
      if (cap_en) begin
        m_q     <= m;
        r_q     <= r;
        sign0_q <= sign0;
        sign1_q <= sign1;
      end
      if (res_en) result <= prod;
    end
  end

endmodule

// File: tb/tb_mul_behav_seq.sv
// Directed bench for mul_behav_seq: reset, RV32M sign modes, back-to-back, abort.
module tb_mul_behav_seq;
  localparam int LAT = 4;

  logic        clk_core = 1'b0;
  logic        reset_n;
  logic        go;
  logic        sign0;
  logic        sign1;
  logic [31:0] m;
  logic [31:0] r;
  logic        done;
  logic [63:0] result;

  int checks   = 0;
  int failures = 0;

  mul_behav_seq #(.LATENCY(LAT)) dut (
    .clk_core(clk_core),
    .reset_n (reset_n),
    .go      (go),
    .sign0   (sign0),
    .sign1   (sign1),
    .m       (m),
    .r       (r),
    .done    (done),
    .result  (result)
  );

  always #5 clk_core = ~clk_core;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  // Caller has already set go=1 and operands for cycle c0; returns edges until done.
  task automatic measure(input bit scramble, output int lat);
    lat = 0;
    while (lat < 40) begin
      tick();
      lat++;
      if (scramble && lat == 1) begin
        m = 32'hDEAD_BEEF;
        r = 32'h1234_5678;
      end
      if (done) break;
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] mv, input logic [31:0] rv,
                       input logic s1, input logic s0, input logic [63:0] exp);
    int lat;
    m = mv; r = rv; sign1 = s1; sign0 = s0; go = 1'b1;
    measure(1'b0, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(LAT));
    chk({tag, "_res"}, result, exp);
    go = 1'b0;
    tick();
    chk({tag, "_done_low"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int lat;
    reset_n = 1'b0; go = 1'b1; sign0 = 1'b1; sign1 = 1'b1;
    m = 32'h0000_0007; r = 32'h0000_0009;
    tick();
    tick();
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_result", result, 64'd0);

    // Release reset with go already high: this cycle is c0.
    reset_n = 1'b1;
    do_op("unsigned_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001);

    do_op("mulh",     32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op("mulhsu",   32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op("s1u_s0s",  32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b1, 64'h0000_0001_FFFF_FFFE);
    do_op("min_sq",   32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000);

    // Back-to-back: go stays high across done; second operands appear in the cycle after done.
    m = 32'd7; r = 32'd9; sign1 = 1'b1; sign0 = 1'b1; go = 1'b1;
    measure(1'b0, lat);
    chk("b2b1_lat", 64'(lat), 64'(LAT));
    chk("b2b1_res", result, 64'd63);
    tick();
    chk("b2b_gap_done", {63'd0, done}, 64'd0);
    m = 32'd3; r = 32'd5;
    measure(1'b1, lat);
    chk("b2b2_spacing", 64'(lat + 1), 64'(LAT + 1));
    chk("b2b2_res", result, 64'h0000_0000_0000_000F);
    go = 1'b0;
    tick();
    chk("b2b2_done_low", {63'd0, done}, 64'd0);

    // Abort: go high c0,c1, low c2,c3, high again from c4.
    m = 32'd100; r = 32'd100; go = 1'b1;
    tick();
    chk("abort_c1_done", {63'd0, done}, 64'd0);
    tick();
    go = 1'b0;
    chk("abort_c2_done", {63'd0, done}, 64'd0);
    tick();
    chk("abort_c3_done", {63'd0, done}, 64'd0);
    chk("abort_c3_res", result, 64'h0000_0000_0000_000F);
    tick();
    chk("abort_c4_done", {63'd0, done}, 64'd0);
    m = 32'd2; r = 32'd21; go = 1'b1;
    measure(1'b0, lat);
    chk("abort_restart_lat", 64'(lat + 4), 64'd8);
    chk("abort_restart_res", result, 64'd42);
    go = 1'b0;
    tick();
    chk("abort_done_low", {63'd0, done}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
